// File: rtl/md_unit_pkg.sv
// md_defs: shared definitions for the multiply/divide unit.
//   - md_op_e    : operation codes carried on md_op
//   - md_state_e : unit FSM states
//   - md_kind_e  : decoded operation class produced by md_calc
//   - default busy-cycle counts for multiply and divide
package md_defs;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9,
    MD_MSUBU = 4'd10
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_e;

  // Operation class: selects busy length and how HI/LO are written.
  typedef enum logic [2:0] {
    K_NONE = 3'd0,
    K_MULT = 3'd1,  // mult/multu and the accumulate variants
    K_DIV  = 3'd2,
    K_MTHI = 3'd3,
    K_MTLO = 3'd4
  } md_kind_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_unit_if.sv
// md_if: issue/result bundle between the EX stage and the md unit.
//   start  : one-cycle issue pulse (stall-qualified)
//   md_op  : operation code (md_defs::md_op_e encoding, raw 4 bits so
//            unknown codes can be presented)
//   A, B   : forwarded rs / rt operands
//   busy   : unit is computing
//   HI, LO : architectural HI/LO registers
// Modports: master = EX stage / issuer, slave = md_unit.
interface md_if;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, md_op, A, B, input  busy, HI, LO);
  modport slave  (input  start, md_op, A, B, output busy, HI, LO);
endinterface

// File: rtl/md_unit_calc.sv
// md_calc: combinational datapath of the multiply/divide unit.
//   md_op_i        : operation code
//   a_i, b_i       : operands (rs, rt)
//   hi_i, lo_i     : current HI/LO (accumulator base for madd/msub)
//   res_o          : 64-bit result, {HI, LO} layout
//   dz_o           : divide op with zero divisor (HI/LO must stay unchanged)
//   kind_o         : decoded operation class
// Optional feature: MD_MADD_EN enables madd/maddu/msub/msubu; without it
// those codes decode as K_NONE.
module md_calc
  import md_defs::*;
(
  input  logic [3:0]  md_op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [63:0] res_o,
  output logic        dz_o,
  output md_kind_e    kind_o
);

  // Lower 64 bits of the product of sign-extended operands is the exact
  // signed 32x32 product.
  logic [63:0] sprod, uprod;
  assign sprod = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
  assign uprod = {32'd0, a_i} * {32'd0, b_i};

  // One unsigned divider shared by div and divu. For div the operands are
  // replaced by magnitudes and signs are restored afterwards; this also
  // gives 0x80000000 / -1 = 0x80000000 rem 0 without special casing.
  logic        is_sdiv, b_zero, q_neg;
  logic [31:0] da, db, uq, ur, sq, sr;
  assign is_sdiv = (md_op_i == MD_DIV);
  assign b_zero  = (b_i == 32'd0);
  assign da      = (is_sdiv && a_i[31]) ? (32'd0 - a_i) : a_i;
  // Divisor forced to 1 when zero so the divider never sees x/0.
  assign db      = b_zero ? 32'd1 :
                   ((is_sdiv && b_i[31]) ? (32'd0 - b_i) : b_i);
  assign uq      = da / db;
  assign ur      = da % db;
  assign q_neg   = a_i[31] ^ b_i[31];
  assign sq      = q_neg   ? (32'd0 - uq) : uq;
  assign sr      = a_i[31] ? (32'd0 - ur) : ur;

`ifdef MD_MADD_EN
  logic [63:0] acc;
  assign acc = {hi_i, lo_i};
`else
  logic unused_acc;
  assign unused_acc = ^{hi_i, lo_i};
`endif

  always_comb begin
    res_o  = 64'd0;
    dz_o   = 1'b0;
    kind_o = K_NONE;
    case (md_op_i)
      MD_MULT:  begin kind_o = K_MULT; res_o = sprod; end
      MD_MULTU: begin kind_o = K_MULT; res_o = uprod; end
      MD_DIV:   begin kind_o = K_DIV;  res_o = {sr, sq}; dz_o = b_zero; end
      MD_DIVU:  begin kind_o = K_DIV;  res_o = {ur, uq}; dz_o = b_zero; end
      MD_MTHI:  kind_o = K_MTHI;
      MD_MTLO:  kind_o = K_MTLO;
`ifdef MD_MADD_EN
      MD_MADD:  begin kind_o = K_MULT; res_o = acc + sprod; end
      MD_MADDU: begin kind_o = K_MULT; res_o = acc + uprod; end
      MD_MSUB:  begin kind_o = K_MULT; res_o = acc - sprod; end
      MD_MSUBU: begin kind_o = K_MULT; res_o = acc - uprod; end
`endif
      default:  kind_o = K_NONE;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit; owns architectural HI/LO.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, aborts any operation
//   bus   : md_if.slave (start, md_op, A, B in; busy, HI, LO out, all
//           outputs registered)
// Parameters: MULT_CYCLES / DIV_CYCLES busy cycles per op class (>= 1).
// Optional feature macro: MD_MADD_EN (madd/msub family, handled in md_calc).
// The result is computed in the start cycle and parked in pend_q; the
// counter only models the architectural latency.
module md_unit
  import md_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  bus
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  md_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [63:0] pend_q;
  logic        pend_dz_q;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;

  logic [63:0] calc_res;
  logic        calc_dz;
  md_kind_e    calc_kind;

  md_calc u_calc (
    .md_op_i (bus.md_op),
    .a_i     (bus.A),
    .b_i     (bus.B),
    .hi_i    (hi_q),
    .lo_i    (lo_q),
    .res_o   (calc_res),
    .dz_o    (calc_dz),
    .kind_o  (calc_kind)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_dz_q <= 1'b0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            case (calc_kind)
              K_MULT: begin
                pend_q    <= calc_res;
                pend_dz_q <= 1'b0;
                cnt_q     <= CW'(MULT_CYCLES);
                busy_q    <= 1'b1;
                state_q   <= S_BUSY;
              end
              K_DIV: begin
                pend_q    <= calc_res;
                pend_dz_q <= calc_dz;
                cnt_q     <= CW'(DIV_CYCLES);
                busy_q    <= 1'b1;
                state_q   <= S_BUSY;
              end
              K_MTHI:  hi_q <= bus.A;
              K_MTLO:  lo_q <= bus.A;
              default: ;
            endcase
          end
        end
        S_BUSY: begin
          // start is ignored here; the hazard unit keeps it from happening.
          if (cnt_q == CW'(1)) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
            if (!pend_dz_q) begin
              hi_q <= pend_q[63:32];
              lo_q <= pend_q[31:0];
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
  import md_defs::*;

  logic clk = 1'b0;
  logic reset;
  md_if bus();

  always #5 clk = ~clk;

  md_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          exp_busy;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one op and count busy cycles (bounded); leaves the bench at the
  // first negedge with busy low.
  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int nbusy);
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = op; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = 1'b0; bus.md_op = 4'd0;
    nbusy = 0;
    while (bus.busy === 1'b1 && nbusy < 40) begin
      nbusy++;
      @(negedge clk);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input int nb, input logic [31:0] hi, input logic [31:0] lo);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp_busy = nb; v.exp_hi = hi; v.exp_lo = lo;
    return v;
  endfunction

  initial begin
    int nb;
    bus.start = 1'b0; bus.md_op = 4'd0; bus.A = '0; bus.B = '0;
    reset = 1'b1;

    // Directed vectors; HI/LO expectations carry over from the previous row.
    vecs.push_back(mk(MD_MULT,  32'hFFFFFFFD, 32'd7,        5,  32'hFFFFFFFF, 32'hFFFFFFEB));
    vecs.push_back(mk(MD_DIVU,  32'd100,      32'd7,        10, 32'd2,        32'd14));
    vecs.push_back(mk(MD_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD));
    vecs.push_back(mk(MD_MTLO,  32'h12345678, 32'd0,        0,  32'hFFFFFFFF, 32'h12345678));
    vecs.push_back(mk(MD_DIVU,  32'd55,       32'd0,        10, 32'hFFFFFFFF, 32'h12345678));
    vecs.push_back(mk(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'd0,        32'h80000000));
    vecs.push_back(mk(MD_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'd1,        32'hFFFFFFFD));
    vecs.push_back(mk(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001));
    vecs.push_back(mk(MD_NONE,  32'hAAAA5555, 32'd3,        0,  32'hFFFFFFFE, 32'h00000001));
    vecs.push_back(mk(4'd11,    32'hAAAA5555, 32'd3,        0,  32'hFFFFFFFE, 32'h00000001));
    vecs.push_back(mk(MD_MULT,  32'h00010000, 32'h00010000, 5,  32'd1,        32'd0));
    vecs.push_back(mk(MD_MTHI,  32'd0,        32'd0,        0,  32'd0,        32'd0));
    vecs.push_back(mk(MD_MTLO,  32'hFFFFFFFF, 32'd0,        0,  32'd0,        32'hFFFFFFFF));
`ifdef MD_MADD_EN
    vecs.push_back(mk(MD_MADD,  32'd1,        32'd1,        5,  32'd1,        32'd0));
    vecs.push_back(mk(MD_MSUBU, 32'd2,        32'd3,        5,  32'd0,        32'hFFFFFFFA));
`else
    vecs.push_back(mk(MD_MADD,  32'd1,        32'd1,        0,  32'd0,        32'hFFFFFFFF));
    vecs.push_back(mk(MD_MSUBU, 32'd2,        32'd3,        0,  32'd0,        32'hFFFFFFFF));
`endif

    // Reset state
    @(negedge clk);
    chk("reset_busy", {63'd0, bus.busy}, 64'd0);
    chk("reset_hilo", {bus.HI, bus.LO}, 64'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, nb);
      chk($sformatf("v%0d_busy_cycles", i), 64'(nb), 64'(vecs[i].exp_busy));
      chk($sformatf("v%0d_hi", i), {32'd0, bus.HI}, {32'd0, vecs[i].exp_hi});
      chk($sformatf("v%0d_lo", i), {32'd0, bus.LO}, {32'd0, vecs[i].exp_lo});
      chk($sformatf("v%0d_noX", i), {63'd0, $isunknown({bus.busy, bus.HI, bus.LO})}, 64'd0);
    end

    // start while busy must be ignored: mult 2*3 with a stray mtlo mid-op.
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = MD_MULT; bus.A = 32'd2; bus.B = 32'd3;
    @(negedge clk);
    bus.md_op = MD_MTLO; bus.A = 32'hDEAD;  // lands in busy cycle 1
    @(negedge clk);
    bus.start = 1'b0; bus.md_op = 4'd0;
    nb = 2;
    while (bus.busy === 1'b1 && nb < 40) begin
      nb++;
      @(negedge clk);
    end
    chk("busy_start_cycles", 64'(nb - 1), 64'd5);
    chk("busy_start_hilo", {bus.HI, bus.LO}, {32'd0, 32'd6});

    // Async reset in busy cycle 3 of multu aborts the op.
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = MD_MULTU; bus.A = 32'hFFFFFFFF; bus.B = 32'hFFFFFFFF;
    @(negedge clk);
    bus.start = 1'b0; bus.md_op = 4'd0;
    chk("abort_busy_c1", {63'd0, bus.busy}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_hilo", {bus.HI, bus.LO}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    nb = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.busy === 1'b1) nb++;
    end
    chk("abort_stays_idle", 64'(nb), 64'd0);
    chk("abort_hilo_held", {bus.HI, bus.LO}, 64'd0);
    issue(MD_MTHI, 32'd5, 32'd0, nb);
    chk("post_abort_mthi", {bus.HI, bus.LO}, {32'd5, 32'd0});
    chk("post_abort_mthi_busy", 64'(nb), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
